// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Pipeline hazard controller for the 5-stage, 16-bit-instruction
//            CPU. It keeps a per-register write-back countdown scoreboard,
//            stalls ID on read-after-write hazards, flushes IF/ID on taken
//            branches and sequences the halt (drain, then freeze).
// Options  : HZD_RF_WRITE_THROUGH_EN - the register file forwards same-cycle
//            WB writes, so a register is busy only while its count is > 1.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int         NUM_REGS    = 16,
  parameter int         WB_LATENCY  = 3,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [3:0]          id_opcode,
  input  logic [3:0]          id_ra,
  input  logic [3:0]          id_rb,
  input  logic                id_uses_ra,
  input  logic                id_uses_rb,
  input  logic                id_writes_ra,
  input  logic                id_writes_rb,
  input  logic                ex_branch_taken,
  output logic                stall,
  output logic                bubble_ex,
  output logic                flush_ifid,
  output logic                halted,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]         stall_cycles
);

  localparam int          CW     = $clog2(WB_LATENCY + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(WB_LATENCY);
  // Register indices come from 4-bit fields; pad the busy vector so the
  // lookup never indexes past its end.
  localparam int          PADW   = (NUM_REGS > 16) ? NUM_REGS : 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q;
  logic [15:0]         stall_cycles_q;
  logic [NUM_REGS-1:0] busy_w;
  logic [NUM_REGS-1:0] nz_w;
  logic [PADW-1:0]     busy_pad_w;
  logic                hazard_w;
  logic                issue_w;
  logic                is_halt_w;
  logic                load_ra_w;
  logic                load_rb_w;

  assign busy_pad_w = PADW'(busy_w);
  assign hazard_w   = id_valid &&
                      ((id_uses_ra && busy_pad_w[id_ra]) ||
                       (id_uses_rb && busy_pad_w[id_rb]));
  assign issue_w    = id_valid && !hazard_w && (state_q == ST_RUN) &&
                      !ex_branch_taken;
  assign is_halt_w  = (id_opcode == HALT_OPCODE);
  // The halt instruction never claims a destination register.
  assign load_ra_w  = issue_w && !is_halt_w && id_writes_ra;
  assign load_rb_w  = issue_w && !is_halt_w && id_writes_rb;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;
      logic          hit_w;

      // ra==rb with both written hits the same counter once, same value.
      assign hit_w = (load_ra_w && (id_ra == 4'(g))) ||
                     (load_rb_w && (id_rb == 4'(g)));

      // Next count: a fresh issue reloads, otherwise count down to zero.
      always_comb begin
        count_d = count_q;
        if (hit_w) begin
          count_d = C_LOAD;
        end else if (count_q != '0) begin
          count_d = count_q - CW'(1);
        end
      end

      // Countdown register for this architectural register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign nz_w[g] = (count_q != '0);
`ifdef HZD_RF_WRITE_THROUGH_EN
      // The WB-cycle write is forwarded by the register file, so the last
      // count is already readable.
      assign busy_w[g] = (count_q > CW'(1));
`else
      assign busy_w[g] = (count_q != '0);
`endif
    end
  endgenerate

  assign busy_mask    = busy_w;
  assign stall_cycles = stall_cycles_q;

  // Halt sequencing and the saturating hazard-stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (issue_w && is_halt_w) begin
            state_q <= ST_DRAIN;
          end
          if (hazard_w && !ex_branch_taken && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (nz_w == '0) begin
            state_q <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Pipeline control: branch beats hazard in RUN; drain/halt hold everything.
  always_comb begin
    stall      = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end else begin
          stall      = hazard_w;
          bubble_ex  = hazard_w;
        end
      end
      ST_DRAIN, ST_HALTED: begin
        stall      = 1'b1;
        bubble_ex  = 1'b1;
      end
      default: begin
        stall      = 1'b0;
      end
    endcase
  end

  assign halted = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Self-checking bench for hazard_scoreboard. Each scenario pushes
//            its expected output vector when it drives a cycle and pops it
//            when the DUT outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_uses_ra, id_uses_rb, id_writes_ra, id_writes_rb;
  logic        ex_branch_taken;
  logic [3:0]  id_opcode, id_ra, id_rb;
  logic        stall, bubble_ex, flush_ifid, halted;
  logic [15:0] busy_mask, stall_cycles;

  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_ra          (id_ra),
    .id_rb          (id_rb),
    .id_uses_ra     (id_uses_ra),
    .id_uses_rb     (id_uses_rb),
    .id_writes_ra   (id_writes_ra),
    .id_writes_rb   (id_writes_rb),
    .ex_branch_taken(ex_branch_taken),
    .stall          (stall),
    .bubble_ex      (bubble_ex),
    .flush_ifid     (flush_ifid),
    .halted         (halted),
    .busy_mask      (busy_mask),
    .stall_cycles   (stall_cycles)
  );

  // Stimulus word: {valid, opcode, ra, rb, uses_ra, uses_rb, wr_ra, wr_rb, branch}
  function automatic logic [17:0] S(input int v, input int op, input int ra, input int rb,
                                    input int ura, input int urb, input int wra,
                                    input int wrb, input int br);
    return {1'(v), 4'(op), 4'(ra), 4'(rb), 1'(ura), 1'(urb), 1'(wra), 1'(wrb), 1'(br)};
  endfunction

  // Expected word: {stall, bubble_ex, flush_ifid, halted, busy_mask, stall_cycles}
  function automatic logic [35:0] E(input int st, input int bu, input int fl, input int ha,
                                    input int m, input int sc);
    return {1'(st), 1'(bu), 1'(fl), 1'(ha), 16'(m), 16'(sc)};
  endfunction

  function automatic logic [35:0] obs();
    return {stall, bubble_ex, flush_ifid, halted, busy_mask, stall_cycles};
  endfunction

  task automatic apply(input logic [17:0] s);
    {id_valid, id_opcode, id_ra, id_rb, id_uses_ra, id_uses_rb,
     id_writes_ra, id_writes_rb, ex_branch_taken} = s;
  endtask

  // Asynchronous pulse away from the clock edge; returns at posedge+1.
  task automatic do_reset();
    apply(S(0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [35:0] got;
    apply(S(0,0,0,0,0,0,0,0,0));
    #1;
    got = obs();
    checks++;
    if (got !== 36'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", got, 36'h0);
    end
    @(posedge clk); #1;
    apply(S(1,1,3,0,0,0,1,0,0));
    @(posedge clk); #1;
    apply(S(1,2,3,0,1,0,0,0,0));
    #1;
    got = obs();
    checks++;
    if (got !== E(1,1,0,0,'h0008,0)) begin
      failures++;
      $display("FAIL reset_prestall got=%h want=%h", got, E(1,1,0,0,'h0008,0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== 36'h0) begin
      failures++;
      $display("FAIL reset_midstall got=%h want=%h", got, 36'h0);
    end
    rst = 1'b0;
    apply(S(0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input logic [17:0] st[$], input logic [35:0] ex[$]);
    logic [35:0] got, want;
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s cycle %0d: got st/bu/fl/ha=%b mask=%h cyc=%0d, want st/bu/fl/ha=%b mask=%h cyc=%0d",
                 name, i, got[35:32], got[31:16], got[15:0], want[35:32], want[31:16], want[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw_stall();
    logic [17:0] st[$];
    logic [35:0] ex[$];
    do_reset();
    st.push_back(S(1,1,3,0,0,0,1,0,0)); ex.push_back(E(0,0,0,0,0,0));
    st.push_back(S(1,2,3,0,1,0,0,0,0)); ex.push_back(E(1,1,0,0,'h0008,0));
    st.push_back(S(1,2,3,0,1,0,0,0,0)); ex.push_back(E(1,1,0,0,'h0008,1));
`ifdef HZD_RF_WRITE_THROUGH_EN
    st.push_back(S(1,2,3,0,1,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2));
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2));
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,2));
`else
    st.push_back(S(1,2,3,0,1,0,0,0,0)); ex.push_back(E(1,1,0,0,'h0008,2));
    st.push_back(S(1,2,3,0,1,0,0,0,0)); ex.push_back(E(0,0,0,0,0,3));
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,3));
`endif
    run_table("raw_stall", st, ex);
  endtask

  task automatic test_dual_write();
    logic [17:0] st[$];
    logic [35:0] ex[$];
    do_reset();
    st.push_back(S(1,1,2,5,0,0,1,1,0)); ex.push_back(E(0,0,0,0,0,0));
    st.push_back(S(1,2,7,0,1,0,0,0,0)); ex.push_back(E(0,0,0,0,'h0024,0));
    st.push_back(S(1,2,0,5,0,1,0,0,0)); ex.push_back(E(1,1,0,0,'h0024,0));
`ifdef HZD_RF_WRITE_THROUGH_EN
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,1));
`else
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,'h0024,1));
`endif
    st.push_back(S(1,1,9,9,0,0,1,1,0)); ex.push_back(E(0,0,0,0,0,1));
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,'h0200,1));
    run_table("dual_write", st, ex);
  endtask

  task automatic test_branch();
    logic [17:0] st[$];
    logic [35:0] ex[$];
    do_reset();
    st.push_back(S(1,1,6,0,0,0,1,0,0)); ex.push_back(E(0,0,0,0,0,0));
    st.push_back(S(1,2,6,9,1,0,0,1,1)); ex.push_back(E(0,1,1,0,'h0040,0));
    st.push_back(S(1,1,8,0,0,0,1,0,1)); ex.push_back(E(0,1,1,0,'h0040,0));
`ifdef HZD_RF_WRITE_THROUGH_EN
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,0));
`else
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,'h0040,0));
`endif
    st.push_back(S(0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0,0,0));
    run_table("branch", st, ex);
  endtask

  task automatic test_halt_drain();
    logic [17:0] st[$];
    logic [35:0] ex[$];
    logic [35:0] got;
    do_reset();
    st.push_back(S(1,1,4,0,0,0,1,0,0));  ex.push_back(E(0,0,0,0,0,0));
    st.push_back(S(1,15,1,0,0,0,1,0,0)); ex.push_back(E(0,0,0,0,'h0010,0));
    st.push_back(S(1,2,4,0,1,0,0,0,1));  ex.push_back(E(1,1,0,0,'h0010,0));
`ifdef HZD_RF_WRITE_THROUGH_EN
    st.push_back(S(1,2,4,0,1,0,0,0,0));  ex.push_back(E(1,1,0,0,0,0));
`else
    st.push_back(S(1,2,4,0,1,0,0,0,0));  ex.push_back(E(1,1,0,0,'h0010,0));
`endif
    st.push_back(S(1,2,4,0,1,0,0,0,1));  ex.push_back(E(1,1,0,0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0));  ex.push_back(E(1,1,0,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,1));  ex.push_back(E(1,1,0,1,0,0));
    st.push_back(S(1,1,3,0,0,0,1,0,1));  ex.push_back(E(1,1,0,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0));  ex.push_back(E(1,1,0,1,0,0));
    run_table("halt_drain", st, ex);
    rst = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== 36'h0) begin
      failures++;
      $display("FAIL reset_halted got=%h want=%h", got, 36'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_halt_flushed();
    logic [17:0] st[$];
    logic [35:0] ex[$];
    do_reset();
    st.push_back(S(1,15,0,0,0,0,0,0,1)); ex.push_back(E(0,1,1,0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0));  ex.push_back(E(0,0,0,0,0,0));
    st.push_back(S(1,1,1,0,0,0,1,0,0));  ex.push_back(E(0,0,0,0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0));  ex.push_back(E(0,0,0,0,'h0002,0));
    run_table("halt_flushed", st, ex);
  endtask

  initial begin
    apply(S(0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    #13;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_raw_stall();
    test_dual_write();
    test_branch();
    test_halt_drain();
    test_halt_flushed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage, 16-bit-instruction CPU.
- Tracks in-flight register writes with a per-register countdown scoreboard, stalls the ID stage on read-after-write hazards, and flushes IF/ID on taken branches.
- Sequences the halt: drains the pipeline, then freezes it.
- Sits beside the control unit. Its outputs drive PC hold, IF/ID hold/flush and ID/EX bubble insertion.

Parameters:
- NUM_REGS, 16, number of architectural registers; the scoreboard depth.
- WB_LATENCY, 3, cycles from ID issue to register-file write (EX, MEM, WB).
- HALT_OPCODE, 4'hF, opcode value in id_opcode that starts the halt drain.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  4  InstructionID[15:12]
- id_ra  in  4  InstructionID[11:8]; source A and primary destination
- id_rb  in  4  InstructionID[7:4]; source B and secondary destination
- id_uses_ra  in  1  instruction reads ra
- id_uses_rb  in  1  instruction reads rb
- id_writes_ra  in  1  instruction writes ra (low half of result)
- id_writes_rb  in  1  instruction writes rb (high half, WriteOP2-style)
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
- stall  out  1  hold PC and IF/ID this cycle
- bubble_ex  out  1  load NOP into ID/EX at the next edge
- flush_ifid  out  1  load NOP into IF/ID at the next edge
- halted  out  1  pipeline frozen after halt
- busy_mask  out  NUM_REGS  bit r = register r has a pending write
- stall_cycles  out  16  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On reset:
  - all counters are 0 and the state is RUN;
  - stall, bubble_ex, flush_ifid and halted are 0;
  - busy_mask is 0 and stall_cycles is 0.
- Scoreboard: one counter per register, width ceil(log2(WB_LATENCY+1)).
  - Each edge, every nonzero counter decrements by 1.
  - An issuing instruction loads its destination counter(s) with WB_LATENCY. The load overrides the decrement.
  - If ra==rb and both are written, only one counter is loaded (same value).
- busy(r): count[r] is nonzero; see Optional Feature for the count==1 case. busy_mask is registered-state based.
- hazard: id_valid and ((id_uses_ra and busy(id_ra)) or (id_uses_rb and busy(id_rb))). Register 0 is not special-cased.
- Issue: id_valid, not hazard, state RUN, not ex_branch_taken.
- States:
  - RUN: stall=hazard and bubble_ex=hazard (combinational).
    - Issue with id_opcode==HALT_OPCODE goes to DRAIN. The halt sets no counters.
  - DRAIN: stall=1, bubble_ex=1. Go to HALTED when all counters are 0.
  - HALTED: stall=1, bubble_ex=1, halted=1. Exit only by reset.
- Branch (RUN only): ex_branch_taken forces flush_ifid=1 and bubble_ex=1 for that cycle, and stall=0.
  - The ID instruction is discarded and sets no counters.
  - Branch overrides hazard, including a halt in ID (no DRAIN entry).
- ex_branch_taken is ignored in DRAIN and HALTED.
- stall_cycles: increments in RUN on cycles where hazard=1 and ex_branch_taken=0. Saturates at 16'hFFFF.
- Latency: a writer issuing at cycle t writes the register file at the end of t+WB_LATENCY. Dependent ID reads stall through t+WB_LATENCY and are released at t+WB_LATENCY+1.
- Reset mid-stall or mid-drain: everything returns to reset values immediately.

Optional Feature:
- Macro: HZD_RF_WRITE_THROUGH_EN.
- Defined: the register file forwards same-cycle WB writes, so busy(r) = count[r] > 1. A dependent read is released one cycle earlier, at t+WB_LATENCY. busy_mask uses the same rule.
- Undefined: busy(r) = count[r] != 0.

Test Plan:
- Reset: rst=1 mid-run with counters set -> all outputs 0 immediately; busy_mask=16'h0000.
- RAW stall: issue writer ra=3 at t, then a reader of ra=3 -> stall=1 and bubble_ex=1 at t+1..t+3, 0 at t+4; stall_cycles=3. With HZD_RF_WRITE_THROUGH_EN: stall at t+1..t+2 only; stall_cycles=2.
- Dual write: id_writes_ra=1 (ra=2) and id_writes_rb=1 (rb=5) -> busy_mask=16'h0024 at t+1; reader of r5 stalls; independent r7 reader does not.
- Branch vs hazard: ex_branch_taken=1 while ID holds a stalled reader -> flush_ifid=1, bubble_ex=1, stall=0; no counter loaded; stall_cycles unchanged.
- Halt drain: writer to r4, then HALT_OPCODE issues next cycle -> DRAIN with stall=1; halted=1 after r4's counter reaches 0, about 3 cycles; stays 1 with ex_branch_taken toggling.
- Halt flushed: HALT_OPCODE in ID with ex_branch_taken=1 -> state stays RUN, halted=0.
